// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag indices, FSM states and CMP codes shared by alu_seq
package alu_pkg;
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;
  localparam logic [7:0] OP_DIV = 8'h03;
  localparam logic [7:0] OP_CMP = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_AND = 8'h09;
  localparam logic [7:0] OP_OR  = 8'h0A;
  localparam logic [7:0] OP_XOR = 8'h0B;
  localparam logic [7:0] OP_SHL = 8'h10;
  localparam logic [7:0] OP_SHR = 8'h11;
  localparam logic [7:0] OP_MOD = 8'h13;
  localparam int F_Z   = 0;
  localparam int F_C   = 1;
  localparam int F_V   = 2;
  localparam int F_N   = 3;
  localparam int F_DZ  = 4;
  localparam int F_ILL = 5;
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: WIDTH-step shift-add multiplier / restoring divider sharing one hi/lo register pair
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] r_cnt;
  logic r_div;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, w_add;
  logic [WIDTH:0] w_sum, w_sh, w_sub;
  logic w_ge;
  // o_hi/o_lo are the values after the current step; the top registers them on the last one
  assign w_add = r_lo[0] ? r_b : '0;
  assign w_sum = {1'b0, r_hi} + {1'b0, w_add};
  assign w_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_sub = w_sh - {1'b0, r_b};
  assign w_ge = ~w_sub[WIDTH];
  assign o_hi = r_div ? (w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign o_lo = r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
  assign o_done = r_cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_b <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(WIDTH);
      r_div <= i_div;
      r_hi <= '0;
      r_lo <= i_a;
      r_b <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_hi <= o_hi;
      r_lo <= o_lo;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result, high word and flags {ILL,DZ,N,V,C,Z}
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int OP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [5:0]       flags
);
  localparam logic [WIDTH-1:0] L_W = WIDTH'(WIDTH);
  state_t r_state, w_nxt;
  logic [OP_W-1:0] r_op;
  logic [WIDTH-1:0] r_res, r_hi, w_res, w_hi, w_it_hi, w_it_lo;
  logic [5:0] r_flags, w_flags;
  logic [WIDTH:0] w_sum, w_dif;
  logic w_acc, w_divop, w_iter, w_start, w_cap, w_done, w_c, w_v, w_dz, w_ill;
  assign in_ready = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign result = r_res;
  assign result_hi = r_hi;
  assign flags = r_flags;
  assign w_acc = in_valid && in_ready;
  assign w_divop = op == OP_DIV || op == OP_MOD;
  assign w_iter = op == OP_MUL || (w_divop && b != '0);
  assign w_start = w_acc && w_iter;
  assign w_cap = (w_acc && !w_iter) || (r_state == S_BUSY && w_done);
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};
  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_start),
    .i_div  (op != OP_MUL),
    .i_a    (a),
    .i_b    (b),
    .o_hi   (w_it_hi),
    .o_lo   (w_it_lo),
    .o_done (w_done)
  );
  // In BUSY the result comes from the iterator; otherwise from the live inputs at the accept edge
  always_comb begin
    w_res = '0;
    w_hi = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    w_dz = 1'b0;
    w_ill = 1'b0;
    if (r_state == S_BUSY) begin
      w_res = r_op == OP_MOD ? w_it_hi : w_it_lo;
      w_hi = r_op == OP_MOD ? w_it_lo : w_it_hi;
      w_c = r_op == OP_MUL && w_it_hi != '0;
      w_v = w_c;
    end else begin
      case (op)
        OP_ADD: begin
          w_res = w_sum[WIDTH-1:0];
          w_c = w_sum[WIDTH];
          w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          w_res = w_dif[WIDTH-1:0];
          w_c = w_dif[WIDTH];
          w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
        end
        OP_MUL: ;
        OP_DIV: begin
          w_res = '1;
          w_hi = a;
          w_dz = 1'b1;
        end
        OP_MOD: begin
          w_res = a;
          w_hi = '1;
          w_dz = 1'b1;
        end
        OP_CMP: w_res = {{(WIDTH-2){1'b0}}, a == b ? CMP_EQ : (a > b ? CMP_GT : CMP_LT)};
        OP_NOT: w_res = ~a;
        OP_AND: w_res = a & b;
        OP_OR:  w_res = a | b;
        OP_XOR: w_res = a ^ b;
        OP_SHL: w_res = b >= L_W ? '0 : a << b;
        OP_SHR: w_res = b >= L_W ? '0 : a >> b;
        default: w_ill = 1'b1;
      endcase
    end
    w_flags = '0;
    w_flags[F_Z] = w_res == '0;
    w_flags[F_C] = w_c;
    w_flags[F_V] = w_v;
    w_flags[F_N] = w_res[WIDTH-1];
    w_flags[F_DZ] = w_dz;
    w_flags[F_ILL] = w_ill;
  end
  always_comb begin
    w_nxt = r_state;
    if (r_state == S_IDLE && w_acc) w_nxt = w_iter ? S_BUSY : S_DONE;
    if (r_state == S_BUSY && w_done) w_nxt = S_DONE;
    if (r_state == S_DONE && out_ready) w_nxt = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_res <= '0;
      r_hi <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) r_op <= op;
      if (w_cap) begin
        r_res <= w_res;
        r_hi <= w_hi;
        r_flags <= w_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors into a scoreboard queue; a negedge monitor checks latency and results
module tb_alu_seq;
  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic [5:0] fl;
    int lat;
    int acc;
    int id;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] op = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] result, result_hi;
  logic [5:0] flags;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic prev_v = 1'b0;
  alu_seq #(.WIDTH(8), .OP_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .flags    (flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] top,
                       input logic [7:0] er, input logic [7:0] eh, input logic [5:0] ef,
                       input int lat, input int id, input bit push);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout id=%0d: in_ready got 0 expected 1", id);
    end
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    if (push) begin
      e.res = er;
      e.hi = eh;
      e.fl = ef;
      e.lat = lat;
      e.acc = cyc + 1;
      e.id = id;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        if (!prev_v) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
        end
      end else begin
        if (!prev_v) chk($sformatf("latency id=%0d", sb[0].id), cyc - sb[0].acc + 1, sb[0].lat);
        if (out_ready) begin
          e = sb.pop_front();
          chk($sformatf("result id=%0d", e.id), {24'd0, result}, {24'd0, e.res});
          chk($sformatf("result_hi id=%0d", e.id), {24'd0, result_hi}, {24'd0, e.hi});
          chk($sformatf("flags id=%0d", e.id), {26'd0, flags}, {26'd0, e.fl});
        end
      end
    end
    prev_v = out_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", {24'd0, result}, 32'd0);
    chk("reset flags", {26'd0, flags}, 32'd0);
    issue(8'hF0, 8'h20, 8'h00, 8'h10, 8'h00, 6'h02, 1, 1, 1); wait_done();
    issue(8'h05, 8'h07, 8'h01, 8'hFE, 8'h00, 6'h0A, 1, 2, 1); wait_done();
    issue(8'h7F, 8'h01, 8'h00, 8'h80, 8'h00, 6'h0C, 1, 3, 1); wait_done();
    issue(8'hFF, 8'hFF, 8'h02, 8'h01, 8'hFE, 6'h06, 9, 4, 1);
    in_valid = 1'b1;
    a = 8'h01;
    b = 8'h01;
    op = 8'h00;
    chk("busy in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("busy in_ready 2", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_done();
    issue(8'd200, 8'd7, 8'h03, 8'd28, 8'd4, 6'h00, 9, 5, 1); wait_done();
    issue(8'd200, 8'd7, 8'h13, 8'd4, 8'd28, 6'h00, 9, 6, 1); wait_done();
    issue(8'd9, 8'd0, 8'h03, 8'hFF, 8'h09, 6'h18, 1, 7, 1); wait_done();
    issue(8'd5, 8'd0, 8'h13, 8'h05, 8'hFF, 6'h10, 1, 8, 1); wait_done();
    issue(8'd3, 8'd9, 8'h04, 8'h02, 8'h00, 6'h00, 1, 9, 1); wait_done();
    issue(8'd9, 8'd3, 8'h04, 8'h01, 8'h00, 6'h00, 1, 10, 1); wait_done();
    issue(8'h81, 8'd1, 8'h10, 8'h02, 8'h00, 6'h00, 1, 11, 1); wait_done();
    issue(8'h80, 8'd8, 8'h11, 8'h00, 8'h00, 6'h01, 1, 12, 1); wait_done();
    issue(8'hFF, 8'd8, 8'h10, 8'h00, 8'h00, 6'h01, 1, 13, 1); wait_done();
    issue(8'h0F, 8'h00, 8'h08, 8'hF0, 8'h00, 6'h08, 1, 14, 1); wait_done();
    issue(8'hAA, 8'h0F, 8'h09, 8'h0A, 8'h00, 6'h00, 1, 15, 1); wait_done();
    issue(8'hA0, 8'h05, 8'h0A, 8'hA5, 8'h00, 6'h08, 1, 16, 1); wait_done();
    issue(8'hF0, 8'hFF, 8'h0B, 8'h0F, 8'h00, 6'h00, 1, 17, 1); wait_done();
    issue(8'h12, 8'h34, 8'h55, 8'h00, 8'h00, 6'h21, 1, 18, 1); wait_done();
    out_ready = 1'b0;
    issue(8'hF0, 8'h20, 8'h00, 8'h10, 8'h00, 6'h02, 1, 19, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp result", {24'd0, result}, 32'h10);
      chk("bp flags", {26'd0, flags}, 32'h02);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'd1, in_ready}, 32'hFFFF_FFFF & {31'd1, 1'b1});
    wait_done();
    issue(8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 6'h00, 9, 20, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort result", {24'd0, result}, 32'd0);
    chk("abort result_hi", {24'd0, result_hi}, 32'd0);
    chk("abort flags", {26'd0, flags}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | out_valid;
      @(posedge clk);
      #1;
    end
    chk("abort no out_valid", {31'd0, seen}, 32'd0);
    issue(8'd1, 8'd1, 8'h00, 8'h02, 8'h00, 6'h00, 1, 21, 1); wait_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU. It keeps the same opcode map and adds registered outputs, a status-flag vector and a full-width product high word.
- Single-cycle ops complete in one clock. MUL is iterative shift-add and DIV/MOD is restoring division, each taking WIDTH clocks.
- Sits between the microprocessor's decode/operand-fetch stage and register writeback, using valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- OP_W, 8, opcode width.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- op  in  OP_W  opcode.
- out_valid  out  1  result, result_hi and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL: product upper half; DIV: remainder; MOD: quotient; otherwise 0.
- flags  out  6  {ILL, DZ, N, V, C, Z}.

Behaviour:
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 MUL, 0x03 DIV (quotient), 0x13 MOD (remainder), 0x04 CMP.
  - 0x08 NOT a, 0x09 AND, 0x0A OR, 0x0B XOR.
  - 0x10 SHL a<<b, 0x11 SHR a>>b (logical).
- Accept: in_valid && in_ready at the rising edge. a, b and op are captured internally; inputs may change afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept of a single-cycle op, or of DIV/MOD with b==0, go to DONE. On accept of MUL, or of DIV/MOD with b!=0, load the iteration counter with WIDTH and go to BUSY.
  - BUSY: one iteration per clock. When the counter reaches 0, go to DONE; the final iteration's result is registered on that edge.
  - DONE: out_valid=1 and outputs stay stable. When out_ready=1, go to IDLE.
- Latency (accept edge = T):
  - Single-cycle ops: out_valid high from T+1.
  - MUL/DIV/MOD: out_valid high from T+WIDTH+1.
  - The next accept is possible no earlier than the edge after the out_ready handshake; there is no overlap.
- Arithmetic:
  - ADD: C = carry-out. V = signed overflow (operands same sign, result sign differs).
  - SUB: a-b mod 2^WIDTH. C = borrow (1 iff a<b unsigned). V = signed overflow.
  - MUL: {result_hi,result} = a*b over the full 2*WIDTH bits. C = V = |result_hi.
  - DIV/MOD with b==0: quotient all-ones, remainder = a, DZ=1, latency 1.
  - CMP: result[1:0] = 2'b00 if a==b, 2'b01 if a>b, 2'b10 if a<b; upper bits 0.
  - SHL/SHR: if b >= WIDTH then result = 0; the shift amount uses the full b value.
  - Logic ops: C = V = 0.
  - Undefined opcode: result = 0, result_hi = 0, ILL=1, latency 1.
  - Z = (result==0), N = result[WIDTH-1], computed on the final result for every op.
- Reset:
  - State goes to IDLE. out_valid=0, result=0, result_hi=0, flags=0, counter=0, in_ready=1 on the cycle after reset.
  - Reset during BUSY or DONE aborts the operation; no out_valid pulse is produced.
- Simultaneous events:
  - reset has priority over everything.
  - in_valid while not IDLE is ignored; in_ready=0.
  - out_ready while not DONE has no effect.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD..OP_SHR and OP_MOD=0x13.
  - Flag bit indices F_Z=0, F_C=1, F_V=2, F_N=3, F_DZ=4, F_ILL=5.
  - FSM state encoding S_IDLE, S_BUSY, S_DONE.
  - CMP codes CMP_EQ, CMP_GT, CMP_LT.
- Sub-module alu_seq_iter: shared WIDTH-step datapath (shift-add multiply / restoring divide) with start, mode, done.
- Single-cycle ops stay inline in alu_seq.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 -> out_valid at T+1, result=0x10, C=1, V=0, Z=0. SUB a=0x05 b=0x07 -> result=0xFE, C=1, N=1.
- MUL a=0xFF b=0xFF -> out_valid exactly at T+9, result=0x01, result_hi=0xFE, C=V=1. During BUSY, in_valid pulses are ignored and in_ready=0.
- DIV a=200 b=7 -> T+9, result=28, result_hi=4. MOD same operands -> result=4, result_hi=28. DIV a=9 b=0 -> T+1, result=0xFF, result_hi=0x09, DZ=1.
- CMP a=3 b=9 -> result=0x02. SHL a=0x81 b=1 -> 0x02. SHR a=0x80 b=8 -> 0x00, Z=1. op=0x55 -> result=0, ILL=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs and flags are stable and in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Assert reset at cycle T+4 of a MUL -> next cycle state IDLE, out_valid never asserts, all outputs 0. A following ADD 1+1 -> result=2 at +1.
